// File: rtl/pixel_bus_pkg.sv
// Shared types and constants for the pixel SRAM bus.
//
// Contents:
//   sram_state_t       responder FSM states (IDLE -> ACCESS -> RESPOND)
//   sram_kind_t        kind of the access latched on accept (RD / WR)
//   W_DATA_BITS        RGB/grey word width
//   SRAM_CNT_BITS      width of the latency counter
//   addr_in_range()    full-width address vs. depth compare
package pixel_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } sram_state_t;

    typedef enum logic {
        RD,
        WR
    } sram_kind_t;

    localparam int W_DATA_BITS   = 24;
    localparam int SRAM_CNT_BITS = 4;

    // The compare is done at full width so that high address bits are
    // never silently discarded before the range decision.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear and programmable rollover.
//
// Ports:
//   clk            system clock
//   n_rst          asynchronous, active-low reset
//   clear          synchronous clear to zero (wins over count_enable)
//   count_enable   advance the count this cycle
//   rollover_val   last value before wrapping back to 1
//   count_out      current count
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            if (count_q == rollover_val) begin
                count_d = NUM_CNT_BITS'(1);
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;

endmodule

// File: rtl/sram_responder.sv
// Memory-side responder for the pixel SRAM bus. Holds a DEPTH x W_DATA_BITS
// store and models a fixed-latency single-port access so the initiator's
// timing can be checked cycle-accurately.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   address                  access address from the initiator
//   read_enable/write_enable level-sensitive request lines
//   w_data                   write data, sampled in the completion cycle
//   r_data                   read data, valid with rd_valid, held otherwise
//   rd_valid / wr_done       1-cycle completion strobes
//   busy                     high while in ACCESS or RESPOND
//   err                      both enables high while idle
//   oob                      completion of an out-of-range access
//   ld_en/ld_addr/ld_data    preload port, honoured only when idle
module sram_responder
    import pixel_bus_pkg::*;
#(
    parameter int W_ADDR_SIZE_BITS = 16,
    parameter int W_DATA_BITS      = pixel_bus_pkg::W_DATA_BITS,
    parameter int DEPTH            = 1024,
    parameter int ACCESS_CYCLES    = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [W_ADDR_SIZE_BITS-1:0] address,
    input  logic                        read_enable,
    input  logic                        write_enable,
    input  logic [W_DATA_BITS-1:0]      w_data,
    output logic [W_DATA_BITS-1:0]      r_data,
    output logic                        rd_valid,
    output logic                        wr_done,
    output logic                        busy,
    output logic                        err,
    output logic                        oob,
    input  logic                        ld_en,
    input  logic [W_ADDR_SIZE_BITS-1:0] ld_addr,
    input  logic [W_DATA_BITS-1:0]      ld_data
);

    localparam int IDX_BITS = $clog2(DEPTH);

    // The counter counts up from 0 after accept; reaching ACCESS_CYCLES-1
    // is the same moment a down-counter loaded with ACCESS_CYCLES-1 hits 0.
    localparam logic [SRAM_CNT_BITS-1:0] LAST_COUNT = SRAM_CNT_BITS'(ACCESS_CYCLES - 1);

    sram_state_t                 state_q, state_d;
    sram_kind_t                  kind_q, kind_d;
    logic [W_ADDR_SIZE_BITS-1:0] addr_q, addr_d;
    logic [W_DATA_BITS-1:0]      r_data_q, r_data_d;

    logic [W_DATA_BITS-1:0]      mem [DEPTH];
    logic                        mem_we;
    logic [IDX_BITS-1:0]         mem_waddr;
    logic [W_DATA_BITS-1:0]      mem_wdata;

    logic                        cnt_clear;
    logic                        cnt_enable;
    logic [SRAM_CNT_BITS-1:0]    cnt_value;
    logic                        cnt_done;
    logic                        cnt_n_rst;

    logic                        addr_ok;
    logic                        ld_ok;
    logic                        kind_enable;

    assign cnt_n_rst   = ~rst;
    assign cnt_done    = (cnt_value == LAST_COUNT);
    assign addr_ok     = addr_in_range(32'(addr_q), 32'(DEPTH));
    assign ld_ok       = addr_in_range(32'(ld_addr), 32'(DEPTH));
    assign kind_enable = (kind_q == RD) ? read_enable : write_enable;

    flex_counter #(
        .NUM_CNT_BITS(SRAM_CNT_BITS)
    ) u_latency_cnt (
        .clk          (clk),
        .n_rst        (cnt_n_rst),
        .clear        (cnt_clear),
        .count_enable (cnt_enable),
        .rollover_val (LAST_COUNT),
        .count_out    (cnt_value)
    );

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        addr_d     = addr_q;
        r_data_d   = r_data_q;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = ld_addr[IDX_BITS-1:0];
        mem_wdata  = ld_data;
        rd_valid   = 1'b0;
        wr_done    = 1'b0;
        busy       = 1'b0;
        err        = 1'b0;
        oob        = 1'b0;

        case (state_q)
            IDLE: begin
                if (read_enable && write_enable) begin
                    err = 1'b1;
                end else if (read_enable || write_enable) begin
                    addr_d    = address;
                    kind_d    = write_enable ? WR : RD;
                    cnt_clear = 1'b1;
                    state_d   = ACCESS;
                end else if (ld_en && ld_ok) begin
                    mem_we = 1'b1;
                end
            end

            ACCESS: begin
                busy = 1'b1;
                // A moved address or a dropped enable cancels the access;
                // whatever is on the bus now is re-evaluated from IDLE.
                if ((address != addr_q) || !kind_enable) begin
                    cnt_clear = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_done) begin
                    state_d = RESPOND;
                    // Read data is captured on the way into RESPOND so it is
                    // presented exactly in the rd_valid cycle.
                    if (kind_q == RD) begin
                        r_data_d = addr_ok ? mem[addr_q[IDX_BITS-1:0]] : '0;
                    end
                end else begin
                    cnt_enable = 1'b1;
                end
            end

            RESPOND: begin
                busy    = 1'b1;
                oob     = ~addr_ok;
                state_d = IDLE;
                if (kind_q == RD) begin
                    rd_valid = 1'b1;
                end else begin
                    wr_done = 1'b1;
                    if (addr_ok) begin
                        mem_we    = 1'b1;
                        mem_waddr = addr_q[IDX_BITS-1:0];
                        mem_wdata = w_data;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            kind_q   <= RD;
            addr_q   <= '0;
            r_data_q <= '0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            addr_q   <= addr_d;
            r_data_q <= r_data_d;
        end
    end

    // Storage is deliberately not reset; it models an external SRAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign r_data = r_data_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed self-checking bench for sram_responder (DEPTH=1024,
// ACCESS_CYCLES=6, so a strobe lands 7 cycles after a request is raised).
module tb_sram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] address;
    logic        read_enable;
    logic        write_enable;
    logic [23:0] w_data;
    logic [23:0] r_data;
    logic        rd_valid;
    logic        wr_done;
    logic        busy;
    logic        err;
    logic        oob;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [23:0] ld_data;

    int vectors     = 0;
    int miscompares = 0;

    sram_responder #(
        .W_ADDR_SIZE_BITS (16),
        .W_DATA_BITS      (24),
        .DEPTH            (1024),
        .ACCESS_CYCLES    (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .address      (address),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .w_data       (w_data),
        .r_data       (r_data),
        .rd_valid     (rd_valid),
        .wr_done      (wr_done),
        .busy         (busy),
        .err          (err),
        .oob          (oob),
        .ld_en        (ld_en),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data)
    );

    always #5 clk = ~clk;

    // One clock cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles until rd_valid or wr_done is seen; 0 means the bound expired.
    task automatic wait_strobe(input int limit, output int cycles);
        cycles = 0;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (rd_valid || wr_done) begin
                cycles = i;
                return;
            end
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [23:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        tick();
        ld_en   = 1'b0;
    endtask

    // Issues a read from idle and returns latency, data and {rd_valid,wr_done,oob}.
    task automatic do_read(input logic [15:0] a, output int lat,
                           output logic [23:0] d, output logic [2:0] f);
        address     = a;
        read_enable = 1'b1;
        wait_strobe(30, lat);
        d = r_data;
        f = {rd_valid, wr_done, oob};
        read_enable = 1'b0;
        tick();
    endtask

    task automatic do_write(input logic [15:0] a, input logic [23:0] d,
                            output int lat, output logic [2:0] f);
        address      = a;
        w_data       = d;
        write_enable = 1'b1;
        wait_strobe(30, lat);
        f = {rd_valid, wr_done, oob};
        write_enable = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        address = '0; read_enable = 1'b0; write_enable = 1'b0;
        w_data = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        tick();
        tick();
        vectors++;
        if (r_data !== 24'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_r_data: got %h expected %h", r_data, 24'h0);
        end
        vectors++;
        if ({rd_valid, wr_done, busy, err, oob} !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b expected %b",
                     {rd_valid, wr_done, busy, err, oob}, 5'b0);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_preload_read();
        int c;
        preload(16'd5, 24'h102030);
        preload(16'd2000, 24'hFFFFFF);
        address     = 16'd5;
        read_enable = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL read_busy: got %b expected %b", busy, 1'b1);
        end
        // A preload while an access is in flight must be ignored.
        ld_addr = 16'd5; ld_data = 24'h000000; ld_en = 1'b1;
        tick();
        ld_en = 1'b0;
        wait_strobe(30, c);
        vectors++;
        if (c + 2 !== 7) begin
            miscompares++;
            $display("[TB] FAIL read_latency: got %0d expected %0d", c + 2, 7);
        end
        vectors++;
        if (r_data !== 24'h102030) begin
            miscompares++;
            $display("[TB] FAIL read_data: got %h expected %h", r_data, 24'h102030);
        end
        vectors++;
        if ({rd_valid, wr_done, oob} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL read_flags: got %b expected %b", {rd_valid, wr_done, oob}, 3'b100);
        end
        read_enable = 1'b0;
        tick();
        vectors++;
        if ({rd_valid, busy, r_data} !== {2'b00, 24'h102030}) begin
            miscompares++;
            $display("[TB] FAIL read_hold: got %b %b %h expected 0 0 %h",
                     rd_valid, busy, r_data, 24'h102030);
        end
    endtask

    task automatic test_write_read();
        int c;
        logic [2:0]  f;
        logic [23:0] d;
        address = 16'd9; w_data = 24'hABCDEF; write_enable = 1'b1;
        wait_strobe(30, c);
        vectors++;
        if (c !== 7) begin
            miscompares++;
            $display("[TB] FAIL write_latency: got %0d expected %0d", c, 7);
        end
        vectors++;
        if ({rd_valid, wr_done, oob, r_data} !== {3'b010, 24'h102030}) begin
            miscompares++;
            $display("[TB] FAIL write_flags: got %b %h expected 010 %h",
                     {rd_valid, wr_done, oob}, r_data, 24'h102030);
        end
        write_enable = 1'b0;
        tick();
        do_read(16'd9, c, d, f);
        vectors++;
        if ({c, d} !== {32'd7, 24'hABCDEF}) begin
            miscompares++;
            $display("[TB] FAIL write_readback: got lat %0d data %h expected 7 %h", c, d, 24'hABCDEF);
        end
    endtask

    task automatic test_conflict();
        int c;
        logic [2:0]  f;
        logic [23:0] d;
        logic        bad;
        address = 16'd9; w_data = 24'h000000;
        read_enable = 1'b1; write_enable = 1'b1;
        #1;
        vectors++;
        if ({err, busy} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL conflict_err: got err %b busy %b expected 1 0", err, busy);
        end
        tick();
        read_enable = 1'b0; write_enable = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (rd_valid || wr_done || busy || err) bad = 1'b1;
            tick();
        end
        vectors++;
        if (bad !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL conflict_quiet: got activity %b expected %b", bad, 1'b0);
        end
        do_read(16'd9, c, d, f);
        vectors++;
        if (d !== 24'hABCDEF) begin
            miscompares++;
            $display("[TB] FAIL conflict_mem: got %h expected %h", d, 24'hABCDEF);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        logic [23:0] exp_data [3];
        exp_data[0] = 24'h111111; exp_data[1] = 24'h222222; exp_data[2] = 24'h333333;
        preload(16'd0, exp_data[0]);
        preload(16'd1, exp_data[1]);
        preload(16'd2, exp_data[2]);
        address = 16'd0; read_enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_strobe(30, c);
            vectors++;
            if (c !== ((k == 0) ? 7 : 8)) begin
                miscompares++;
                $display("[TB] FAIL seq_spacing[%0d]: got %0d expected %0d", k, c, (k == 0) ? 7 : 8);
            end
            vectors++;
            if (r_data !== exp_data[k]) begin
                miscompares++;
                $display("[TB] FAIL seq_data[%0d]: got %h expected %h", k, r_data, exp_data[k]);
            end
            if (k < 2) address = address + 16'd1;
            else read_enable = 1'b0;
        end
        tick();
    endtask

    task automatic test_addr_change();
        int c;
        address = 16'd0; read_enable = 1'b1;
        tick();
        tick();
        tick();
        address = 16'd1;
        tick();
        vectors++;
        if ({busy, rd_valid} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL abort_idle: got busy %b rd_valid %b expected 0 0", busy, rd_valid);
        end
        wait_strobe(30, c);
        vectors++;
        if ({c, r_data} !== {32'd7, 24'h222222}) begin
            miscompares++;
            $display("[TB] FAIL abort_reaccept: got lat %0d data %h expected 7 %h", c, r_data, 24'h222222);
        end
        read_enable = 1'b0;
        tick();
    endtask

    task automatic test_oob();
        int c;
        logic [2:0]  f;
        logic [23:0] d;
        do_read(16'd2000, c, d, f);
        vectors++;
        if ({c, d, f} !== {32'd7, 24'h000000, 3'b101}) begin
            miscompares++;
            $display("[TB] FAIL oob_read: got lat %0d data %h flags %b expected 7 000000 101", c, d, f);
        end
    endtask

    task automatic test_reset_mid_access();
        int c;
        logic [2:0]  f;
        logic [23:0] d;
        address = 16'd9; w_data = 24'h555555; write_enable = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        vectors++;
        if ({rd_valid, wr_done, busy, err, oob, r_data} !== 29'b0) begin
            miscompares++;
            $display("[TB] FAIL midrst_outputs: got %b %h expected 00000 000000",
                     {rd_valid, wr_done, busy, err, oob}, r_data);
        end
        write_enable = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        do_read(16'd9, c, d, f);
        vectors++;
        if (d !== 24'hABCDEF) begin
            miscompares++;
            $display("[TB] FAIL midrst_nowrite: got %h expected %h", d, 24'hABCDEF);
        end
        do_write(16'd9, 24'h123456, c, f);
        vectors++;
        if ({c, f} !== {32'd7, 3'b010}) begin
            miscompares++;
            $display("[TB] FAIL midrst_write: got lat %0d flags %b expected 7 010", c, f);
        end
        do_read(16'd9, c, d, f);
        vectors++;
        if (d !== 24'h123456) begin
            miscompares++;
            $display("[TB] FAIL midrst_readback: got %h expected %h", d, 24'h123456);
        end
    endtask

    initial begin
        test_reset();
        test_preload_read();
        test_write_read();
        test_conflict();
        test_back_to_back();
        test_addr_change();
        test_oob();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule
